// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped cache line store.
// State encoding and tag width helper.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic int tag_w(input int addr_w,
                                 input int index_w,
                                 input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Word-addressed data array: one write port, one registered read port.
// Same-address write and read in one cycle returns the new word.
module cache_data_ram #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cache_line_store.sv
// Direct-mapped cache storage: tags, valid bits, hit compare,
// multi-beat line refill and a one-line-per-cycle flush.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_ready,
    input  logic              flush,
    output logic              busy
);

    localparam int TAG_W = tag_w(ADDR_W, INDEX_W, OFFSET_W);
    localparam int LINES = 2**INDEX_W;
    localparam int RAM_AW = INDEX_W + OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = '1;
    localparam logic [INDEX_W-1:0] LAST_IDX = '1;

    generate
        if (TAG_W < 1) begin : g_bad_tag
            $error("cache_line_store: TAG_W must be >= 1");
        end
    endgenerate

    state_t              state;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_arr [LINES];
    logic [OFFSET_W-1:0] beat_cnt;
    logic [INDEX_W-1:0]  flush_idx;
    logic [INDEX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                rsp_rd;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic                hit;
    logic                accept;
    logic                wr_hit;
    logic                fill_we;
    logic                last_beat;
    logic                unused;
    logic                ram_we;
    logic [RAM_AW-1:0]   ram_waddr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_q;

    assign unused = ^fill_addr[OFFSET_W-1:0];

    assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx = req_addr[OFFSET_W +: INDEX_W];
    assign hit     = valid[req_idx] && (tag_arr[req_idx] == req_tag);

    assign req_ready = (state == IDLE) && !flush && !fill_start;
    assign accept    = req_ready && req_valid;
    assign wr_hit    = accept && req_write && hit;
    assign fill_we   = (state == FILL) && fill_valid;
    assign last_beat = fill_we && (beat_cnt == LAST_BEAT);

    assign fill_ready = (state == FILL);
    assign busy       = (state != IDLE);

    assign ram_we    = fill_we || wr_hit;
    assign ram_waddr = fill_we ? {fill_idx, beat_cnt}
                               : req_addr[RAM_AW-1:0];
    assign ram_wdata = fill_we ? fill_data : req_wdata;

    cache_data_ram #(
        .AW(RAM_AW),
        .DW(DATA_W)
    ) u_data (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(req_addr[RAM_AW-1:0]),
        .rdata(ram_q)
    );

    // Data RAM output is unreset; gate it so misses and writes read 0.
    assign rsp_rdata = (rsp_hit && rsp_rd) ? ram_q : '0;

    always_ff @(posedge clk) begin
        if (last_beat) begin
            tag_arr[fill_idx] <= fill_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            beat_cnt  <= '0;
            flush_idx <= '0;
            fill_idx  <= '0;
            fill_tag  <= '0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_rd    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_rd    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (flush) begin
                        flush_idx <= '0;
                        state     <= FLUSH;
                    end else if (fill_start) begin
                        fill_tag  <= fill_addr[ADDR_W-1 -: TAG_W];
                        fill_idx  <= fill_addr[OFFSET_W +: INDEX_W];
                        valid[fill_addr[OFFSET_W +: INDEX_W]] <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= FILL;
                    end else if (req_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_hit   <= hit;
                        rsp_rd    <= !req_write;
                    end
                end
                FILL: begin
                    if (fill_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (last_beat) begin
                        valid[fill_idx] <= 1'b1;
                        state           <= IDLE;
                    end
                end
                FLUSH: begin
                    valid[flush_idx] <= 1'b0;
                    flush_idx        <= flush_idx + 1'b1;
                    if (flush_idx == LAST_IDX) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
